// File: rtl/viterbi_frame_ctrl.sv
`default_nettype none
// viterbi_frame_ctrl: per-frame sequencer for a Viterbi core. It feeds cfg_len
// host symbols, appends FLUSH_N zero symbols, and forwards exactly cfg_len decoded bits.
module viterbi_frame_ctrl #(
  parameter int LEN_W   = 12,
  parameter int FLUSH_N = 6,
  parameter int TMO     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_term,
  input  logic             in_sym_valid,
  output logic             in_sym_ready,
  input  logic [1:0]       in_sym,
  output logic             core_sym_valid,
  input  logic             core_sym_ready,
  output logic [1:0]       core_sym,
  input  logic             core_dec_valid,
  input  logic             core_dec_bit,
  output logic             core_force_state0,
  output logic             out_bit_valid,
  output logic             out_bit,
  output logic             out_bit_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int FL_W = $clog2(FLUSH_N + 1);
  localparam int TM_W = $clog2(TMO + 1);
  localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_N - 1);
  localparam logic [TM_W-1:0] TMO_LAST   = TM_W'(TMO - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_last;
  logic [LEN_W-1:0] sym_cnt;
  logic [LEN_W-1:0] bit_cnt;
  logic             term;
  logic [FL_W-1:0]  flush_cnt;
  logic [TM_W-1:0]  tmo_cnt;
  logic             core_hs;
  logic             take_bit;

  assign len_last = len - LEN_W'(1);
  assign core_hs  = core_sym_valid && core_sym_ready;
  assign take_bit = core_dec_valid && (bit_cnt < len) &&
                    ((state == FEED) || (state == FLUSH) || (state == DRAIN));

  // Host-to-core path is purely combinational so FEED adds no latency.
  always_comb begin
    in_sym_ready   = 1'b0;
    core_sym_valid = 1'b0;
    core_sym       = 2'b00;
    if (state == FEED) begin
      in_sym_ready   = core_sym_ready;
      core_sym_valid = in_sym_valid;
      core_sym       = in_sym;
    end else if (state == FLUSH) begin
      core_sym_valid = 1'b1;
    end
  end

  assign busy              = (state != IDLE);
  assign core_force_state0 = busy ? term : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      term          <= 1'b0;
      sym_cnt       <= '0;
      bit_cnt       <= '0;
      flush_cnt     <= '0;
      tmo_cnt       <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
      out_bit_valid <= 1'b0;
      out_bit       <= 1'b0;
      out_bit_last  <= 1'b0;
    end else begin
      out_bit_valid <= 1'b0;
      out_bit_last  <= 1'b0;
      done          <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            err <= 1'b0;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              len       <= cfg_len;
              term      <= cfg_term;
              sym_cnt   <= '0;
              bit_cnt   <= '0;
              flush_cnt <= '0;
              tmo_cnt   <= '0;
              state     <= FEED;
            end
          end
        end
        FEED: begin
          if (core_hs) begin
            sym_cnt <= sym_cnt + LEN_W'(1);
            if (sym_cnt == len_last) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (core_hs) begin
            flush_cnt <= flush_cnt + FL_W'(1);
            if (flush_cnt == FLUSH_LAST) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (core_dec_valid) begin
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TM_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // The final decoded bit ends the frame from any active state.
      if (take_bit) begin
        out_bit_valid <= 1'b1;
        out_bit       <= core_dec_bit;
        out_bit_last  <= (bit_cnt == len_last);
        bit_cnt       <= bit_cnt + LEN_W'(1);
        if (bit_cnt == len_last) begin
          state <= DONE;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_viterbi_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for viterbi_frame_ctrl: behavioural core agent, a frame-level model
// compared every cycle, and directed frames with literal expectations.
module tb_viterbi_frame_ctrl;
  localparam int LEN_W = 12, FLUSH_N = 6, TMO = 64;

  logic clk = 1'b0;
  logic rst, start, cfg_term;
  logic [LEN_W-1:0] cfg_len;
  logic in_sym_valid, in_sym_ready, core_sym_valid, core_sym_ready;
  logic [1:0] in_sym, core_sym;
  logic core_dec_valid, core_dec_bit, core_force_state0;
  logic out_bit_valid, out_bit, out_bit_last, busy, done, err;

  viterbi_frame_ctrl #(.LEN_W(LEN_W), .FLUSH_N(FLUSH_N), .TMO(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_term(cfg_term),
    .in_sym_valid(in_sym_valid), .in_sym_ready(in_sym_ready), .in_sym(in_sym),
    .core_sym_valid(core_sym_valid), .core_sym_ready(core_sym_ready), .core_sym(core_sym),
    .core_dec_valid(core_dec_valid), .core_dec_bit(core_dec_bit),
    .core_force_state0(core_force_state0), .out_bit_valid(out_bit_valid),
    .out_bit(out_bit), .out_bit_last(out_bit_last), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural core / host agent ----------------
  int frame_id = 0, seen_id = 0;
  logic [1:0] host_syms [0:63];
  int n_host = 0, lag = 6, emit_max = 0;
  bit ready_toggle = 0, gap_mode = 0, free_run = 0, zero_bits = 0;
  int idx = 0, a_rx = 0, a_em = 0, rx_total = 0;
  logic [1:0] rx_log [0:1023];
  bit hs_host;

  initial begin
    in_sym_valid = 0; in_sym = 0; core_sym_ready = 1; core_dec_valid = 0; core_dec_bit = 0;
    forever begin
      @(negedge clk);
      hs_host = in_sym_valid && in_sym_ready;
      if (core_sym_valid && core_sym_ready) begin
        rx_log[rx_total] = core_sym;
        rx_total++;
        a_rx++;
      end
      @(posedge clk); #2;
      if (frame_id != seen_id) begin
        seen_id = frame_id; idx = 0; a_rx = 0; a_em = 0;
      end else begin
        if (hs_host) idx++;
        if (core_dec_valid) a_em++;
      end
      in_sym_valid   = (idx < n_host) && (!gap_mode || $urandom_range(0, 3) != 0);
      in_sym         = (idx < n_host) ? host_syms[idx] : 2'b11;
      core_sym_ready = ready_toggle ? ~core_sym_ready : 1'b1;
      core_dec_valid = (a_em < emit_max) && (free_run ? (a_rx > 0) : (a_rx > a_em + lag));
      core_dec_bit   = zero_bits ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // ---------------- frame-level model ----------------
  // m_ph: 0 = no frame, 1 = frame in progress, 2 = completion cycle.
  int m_ph = 0, m_sent = 0, m_bits = 0, m_silent = 0;
  int m_len = 0;
  logic m_term = 0, m_err = 0, e_obv = 0, e_bit = 0, e_last = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph = 0; m_sent = 0; m_bits = 0; m_silent = 0; m_len = 0;
      m_term = 0; m_err = 0; e_obv = 0; e_bit = 0; e_last = 0;
    end else begin
      e_obv = 0;
      if (m_ph == 0) begin
        if (start) begin
          m_err = 0;
          if (cfg_len == 0) m_ph = 2;
          else begin
            m_len = int'(cfg_len); m_term = cfg_term;
            m_sent = 0; m_bits = 0; m_silent = 0; m_ph = 1;
          end
        end
      end else if (m_ph == 2) begin
        m_ph = 0;
      end else begin
        automatic bit drain = (m_sent >= m_len + FLUSH_N);
        if (m_sent < m_len) begin
          if (in_sym_valid && core_sym_ready) m_sent++;
        end else if (!drain && core_sym_ready) m_sent++;
        if (core_dec_valid) begin
          m_silent = 0; m_bits++;
          e_obv = 1; e_bit = core_dec_bit; e_last = (m_bits == m_len);
          if (e_last) m_ph = 2;
        end else if (drain) begin
          m_silent++;
          if (m_silent == TMO) begin m_err = 1; m_ph = 2; end
        end
      end
    end
  end

  // ---------------- per-cycle compare and monitors ----------------
  int cyc = 0, n_obv = 0, n_last = 0, n_done = 0, last_obv_cyc = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      automatic bit host  = (m_ph == 1) && (m_sent < m_len);
      automatic bit flush = (m_ph == 1) && !host && (m_sent < m_len + FLUSH_N);
      cyc++;
      chk("busy", busy, m_ph != 0);
      chk("done", done, m_ph == 2);
      chk("err", err, m_err);
      chk("force_state0", core_force_state0, (m_ph == 0) ? 1'b1 : m_term);
      chk("out_bit_valid", out_bit_valid, e_obv);
      if (e_obv) begin
        chk("out_bit", out_bit, e_bit);
        chk("out_bit_last", out_bit_last, e_last);
      end
      if (host) begin
        chk("feed core_sym_valid", core_sym_valid, in_sym_valid);
        chk("feed in_sym_ready", in_sym_ready, core_sym_ready);
        if (in_sym_valid) chk("feed core_sym", core_sym, in_sym);
      end else if (flush) begin
        chk("flush core_sym_valid", core_sym_valid, 1);
        chk("flush core_sym", core_sym, 0);
        chk("flush in_sym_ready", in_sym_ready, 0);
      end else begin
        chk("idle core_sym_valid", core_sym_valid, 0);
        chk("idle in_sym_ready", in_sym_ready, 0);
      end
      if (out_bit_valid) begin n_obv++; last_obv_cyc = cyc; end
      if (out_bit_valid && out_bit_last) n_last++;
      if (done) begin n_done++; done_cyc = cyc; end
    end
  end

  // ---------------- directed sequence ----------------
  task automatic check_reset_vals(input string tag);
    chk({tag, " in_sym_ready"}, in_sym_ready, 0);
    chk({tag, " core_sym_valid"}, core_sym_valid, 0);
    chk({tag, " core_sym"}, core_sym, 0);
    chk({tag, " out_bit_valid"}, out_bit_valid, 0);
    chk({tag, " out_bit"}, out_bit, 0);
    chk({tag, " out_bit_last"}, out_bit_last, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
    chk({tag, " force_state0"}, core_force_state0, 1);
  endtask

  task automatic run_frame(input int len, input bit term);
    @(posedge clk); #1;
    cfg_len = LEN_W'(len); cfg_term = term; start = 1; frame_id++;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    bit seen = 0;
    while (!seen && k < budget) begin
      @(negedge clk);
      if (done) seen = 1;
      k++;
    end
    if (!seen) chk({nm, " done timeout"}, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic setup(input int nh, input bit zero, input bit tog, input bit gap,
                       input bit fr, input int lg, input int em);
    n_host = nh; ready_toggle = tog; gap_mode = gap; free_run = fr; lag = lg; emit_max = em;
    zero_bits = zero;
    for (int i = 0; i < nh; i++) host_syms[i] = zero ? 2'b00 : 2'($urandom_range(0, 3));
  endtask

  int b_rx, b_obv, b_last, b_done;
  task automatic snap();
    b_rx = rx_total; b_obv = n_obv; b_last = n_last; b_done = n_done;
  endtask

  initial begin
    rst = 1; start = 0; cfg_len = 0; cfg_term = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 0;

    // all-zero terminated frame
    setup(10, 1, 0, 0, 0, 6, 100); snap();
    run_frame(10, 1); wait_done("t1", 300);
    chk("t1 core handshakes", rx_total - b_rx, 16);
    for (int i = 0; i < 16; i++) chk("t1 core sym zero", rx_log[b_rx + i], 0);
    chk("t1 bits", n_obv - b_obv, 10);
    chk("t1 last count", n_last - b_last, 1);
    chk("t1 last with done", done_cyc - last_obv_cyc, 0);
    chk("t1 err", err, 0);

    // backpressure, gapped host
    setup(8, 0, 1, 1, 0, 6, 100); snap();
    run_frame(8, 0); wait_done("t2", 400);
    chk("t2 core handshakes", rx_total - b_rx, 14);
    for (int i = 0; i < 14; i++)
      chk("t2 core sym order", rx_log[b_rx + i], (i < 8) ? host_syms[i] : 2'b00);
    chk("t2 bits", n_obv - b_obv, 8);

    // excess decoded bits are discarded
    setup(12, 0, 0, 0, 1, 0, 20); snap();
    run_frame(12, 1); wait_done("t3", 300);
    repeat (15) @(posedge clk);
    #1;
    chk("t3 bits", n_obv - b_obv, 12);
    chk("t3 last count", n_last - b_last, 1);

    // timeout
    setup(10, 0, 0, 0, 0, 11, 5); snap();
    run_frame(10, 1); wait_done("t4", 400);
    chk("t4 bits", n_obv - b_obv, 5);
    chk("t4 last count", n_last - b_last, 0);
    chk("t4 err", err, 1);
    chk("t4 timeout gap", done_cyc - last_obv_cyc, 64);

    // zero length clears err
    setup(0, 0, 0, 0, 0, 6, 0); snap();
    run_frame(0, 0);
    @(negedge clk);
    chk("t5 zero-len done", done, 1);
    chk("t5 zero-len err", err, 0);
    @(posedge clk); #1;
    chk("t5 zero-len handshakes", rx_total - b_rx, 0);
    chk("t5 zero-len done count", n_done - b_done, 1);

    // start while busy
    setup(6, 0, 0, 0, 0, 6, 100); snap();
    run_frame(6, 0);
    repeat (2) @(posedge clk);
    #1;
    cfg_len = 3; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done("t5b", 300);
    repeat (3) @(posedge clk);
    #1;
    chk("t5b done count", n_done - b_done, 1);
    chk("t5b bits", n_obv - b_obv, 6);
    chk("t5b core handshakes", rx_total - b_rx, 12);

    // reset mid-frame, then a normal frame
    setup(8, 0, 0, 0, 0, 6, 100);
    run_frame(8, 1);
    repeat (3) @(posedge clk);
    #3; rst = 1; #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    rst = 0;
    setup(4, 0, 0, 0, 0, 6, 100); snap();
    run_frame(4, 0); wait_done("t6", 300);
    chk("t6 bits", n_obv - b_obv, 4);
    chk("t6 last count", n_last - b_last, 1);
    chk("t6 done count", n_done - b_done, 1);
    chk("t6 core handshakes", rx_total - b_rx, 10);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

- Frame-level sequencer between a host symbol stream and `tt_um_viterbi_core`.
- For each frame it:
  - passes exactly `cfg_len` received symbols into the core;
  - appends `FLUSH_N` all-zero flush symbols so traceback releases the tail bits;
  - forwards exactly `cfg_len` decoded bits, tagging the final one with `out_bit_last`;
  - signals frame completion or timeout.
- It drives `core_force_state0` so the core handles terminated and unterminated frames.

## Interface
Parameters:
- `LEN_W`, 12 — width of the frame-length and bit counters; maximum frame is 2^LEN_W−1 symbols.
- `FLUSH_N`, 6 — number of zero symbols injected after the frame; set equal to core `D`.
- `TMO`, 64 — idle-cycle limit in DRAIN before the timeout abort.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `start` in 1 — frame start pulse; ignored unless IDLE.
- `cfg_len` in LEN_W — info bits (= symbols) per frame; latched on start.
- `cfg_term` in 1 — frame is tail-terminated; latched on start.
- `in_sym_valid` in 1; `in_sym_ready` out 1; `in_sym` in 2 — host symbol handshake.
- `core_sym_valid` out 1; `core_sym_ready` in 1; `core_sym` out 2 — to core `rx_sym_*`.
- `core_dec_valid` in 1; `core_dec_bit` in 1 — from core `dec_bit_valid` / `dec_bit`.
- `core_force_state0` out 1 — to core `force_state0`.
- `out_bit_valid` out 1; `out_bit` out 1; `out_bit_last` out 1 — decoded output, no backpressure.
- `busy` out 1 — state ≠ IDLE.
- `done` out 1 — one-cycle frame-complete pulse.
- `err` out 1 — timeout flag; valid with done.

## Operation
- **States:** IDLE, FEED, FLUSH, DRAIN, DONE.

**IDLE**
- `in_sym_ready`=0, `core_sym_valid`=0; `core_dec_valid` is ignored.
- On `start` with `cfg_len`≠0:
  - latch `len` and `term`;
  - clear `sym_cnt`, `bit_cnt`, `flush_cnt`, `tmo_cnt` and `err`;
  - go to FEED.
- On `start` with `cfg_len`=0: go to DONE, `err`=0, no core handshakes.

**FEED** (combinational pass-through)
- `core_sym_valid`=`in_sym_valid`, `core_sym`=`in_sym`, `in_sym_ready`=`core_sym_ready`.
- `sym_cnt` increments on each core handshake.
- The handshake with `sym_cnt`==len−1 moves the state to FLUSH.

**FLUSH**
- `in_sym_ready`=0, `core_sym_valid`=1, `core_sym`=2'b00.
- `flush_cnt` increments per handshake; the handshake with `flush_cnt`==FLUSH_N−1 moves the state to DRAIN.

**DRAIN**
- No symbols are sent.
- `tmo_cnt` increments each cycle without `core_dec_valid` and clears on `core_dec_valid`.
- When `tmo_cnt`==TMO−1 with no bit: go to DONE, set `err`=1.

**Output path** (active in FEED, FLUSH and DRAIN)
- On `core_dec_valid` with `bit_cnt`<len, register:
  - `out_bit`=`core_dec_bit`;
  - `out_bit_valid`=1;
  - `out_bit_last`=(`bit_cnt`==len−1).
  - Then `bit_cnt`++.
- Decoded bits with `bit_cnt`≥len are discarded.
- Registering the last bit moves the state to DONE from any of FEED/FLUSH/DRAIN; any remaining flush symbols are abandoned.

**DONE**
- `done`=1 for exactly one cycle, then IDLE.
- `err` holds until the next accepted start.

**core_force_state0**
- Equals latched `term` while busy, and 1 in IDLE.

**Counter rules**
- `sym_cnt` and `bit_cnt` are LEN_W bits and never wrap (bounded by len).
- `flush_cnt` is sized clog2(FLUSH_N+1).
- `tmo_cnt` is sized clog2(TMO+1).

**Edge cases**
- `start` while busy: no effect.
- `rst` mid-frame: immediate IDLE; all counters 0; all outputs at reset values.
- The core shares `rst`, so no partial state survives a reset.

## Timing
- **Reset values:** `in_sym_ready`, `core_sym_valid`, `core_sym`, `out_bit_valid`, `out_bit`, `out_bit_last`, `busy`, `done` and `err` are 0; `core_force_state0` is 1.
- **Start:** `start` sampled in cycle t → FEED in t+1; the first symbol can pass in t+1.
- **FEED:** zero-cycle latency from host to core, valid and ready both combinational.
- **FEED→FLUSH:** flush symbols are presented in the cycle after the last host handshake.
- **Output latency:** `out_bit_valid` asserts exactly one cycle after `core_dec_valid` is sampled.
- **Frame end:** `done` is coincident with the `out_bit_last` cycle. On timeout or zero-length, `done` appears with `out_bit_valid`=0.
- **busy:** asserted from t+1 after start through the `done` cycle inclusive.
- **Next frame:** earliest accepted start is the cycle after `done`.

## Test plan
1. **Real core, all-zero frame.**
   - Setup: real `tt_um_viterbi_core` (K=3, D=6, G=7/5), len=10, term=1, ten 00 symbols.
   - Required: 10 host handshakes then 6 core-side 00 flush handshakes; 10 `out_bit`=0; `out_bit_last` on the 10th; `done` in the same cycle; `err`=0.
2. **Backpressure.**
   - Setup: behavioral core with `core_sym_ready` toggling every cycle, len=8.
   - Required: exactly 8 host symbols reach the core in order, unchanged; exactly 6 flush symbols; no duplicates or drops.
3. **Discard excess bits.**
   - Setup: behavioral core emits 20 decoded bits, len=12.
   - Required: exactly 12 `out_bit_valid` pulses, the last flagged; the remaining 8 bits are dropped.
4. **Timeout.**
   - Setup: behavioral core emits 5 bits then goes silent, len=10, TMO=64.
   - Required: 5 output bits with no `last`; `done` and `err`=1 64 cycles after the last bit; `err` clears on the next start.
5. **Zero length and start while busy.**
   - `cfg_len`=0 start: `done` one cycle later, no core handshakes.
   - `start` pulsed mid-FEED: ignored; frame count unchanged.
6. **Reset mid-frame.**
   - Stimulus: `rst` pulsed during FEED.
   - Required: all outputs at reset values immediately, `in_sym_ready`=0. A following len=4 frame completes normally with 4 bits and `done`.
